// File: rtl/vm_pkg.sv
// Shared vending-machine constants: button channel indices and the default debounce length.
package vm_pkg;

  localparam int CH_COIN   = 0;
  localparam int CH_COFFEE = 1;
  localparam int CH_SPRITE = 2;
  localparam int NUM_CH    = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // One-hot of the lowest set bit; channel 0 (coin) wins over higher indices.
  function automatic logic [NUM_CH-1:0] priority_grant(input logic [NUM_CH-1:0] req);
    return req & (~req + NUM_CH'(1));
  endfunction

endpackage

// File: rtl/vm_btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce filter, rising-edge strobe.
// VM_BTN_ACTIVE_LOW_EN: raw input is pressed-low and is inverted ahead of the synchronizer.
module vm_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_pressed;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;

`ifdef VM_BTN_ACTIVE_LOW_EN
  assign btn_pressed = ~btn;
`else
  assign btn_pressed = btn;
`endif

  // The new level is accepted on the edge where the count reaches its last value.
  assign accept = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);
  assign rise   = accept && sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= btn_pressed;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vm_button_conditioner.sv
// Conditions coin/coffee/sprite buttons and serializes them into one-hot single-cycle requests.
module vm_button_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_coin,
  input  logic i_btn_coffee,
  input  logic i_btn_sprite,
  output logic o_coin,
  output logic o_coffee,
  output logic o_sprite,
  output logic o_busy
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] pending_reg;
  logic [NUM_CH-1:0] req_reg;

  assign raw[CH_COIN]   = i_btn_coin;
  assign raw[CH_COFFEE] = i_btn_coffee;
  assign raw[CH_SPRITE] = i_btn_sprite;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      vm_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  assign grant = priority_grant(pending_reg);

  // A rise landing on the cycle its own flag is issued re-arms the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      req_reg     <= '0;
    end else begin
      pending_reg <= (pending_reg & ~grant) | rise;
      req_reg     <= grant;
    end
  end

  assign o_coin   = req_reg[CH_COIN];
  assign o_coffee = req_reg[CH_COFFEE];
  assign o_sprite = req_reg[CH_SPRITE];
  assign o_busy   = |pending_reg;

endmodule

// File: tb/tb_vm_button_conditioner.sv
// Randomized self-checking bench for vm_button_conditioner with a window-based reference model.
module tb_vm_button_conditioner;

  localparam int DC = 4;
`ifdef VM_BTN_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [2:0] press;
  logic btn_coin, btn_coffee, btn_sprite;
  logic o_coin, o_coffee, o_sprite, o_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign btn_coin   = press[0] ^ ACT_LOW;
  assign btn_coffee = press[1] ^ ACT_LOW;
  assign btn_sprite = press[2] ^ ACT_LOW;

  vm_button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn_coin   (btn_coin),
    .i_btn_coffee (btn_coffee),
    .i_btn_sprite (btn_sprite),
    .o_coin       (o_coin),
    .o_coffee     (o_coffee),
    .o_sprite     (o_sprite),
    .o_busy       (o_busy)
  );

  // Reference model: samp[c][0] is the press level sampled at the previous edge.
  // The debounced level becomes v at edge k when the DC samples taken at edges
  // k-DC-1 .. k-2 all equal v and v differs from the current debounced level.
  bit         samp [3][DC+1];
  bit         deb_m [3];
  logic [2:0] pend_m;
  logic [2:0] out_m;

  task automatic tick();
    logic [2:0] rise;
    bit         all_same;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i <= DC; i++) samp[c][i] = 1'b0;
        deb_m[c] = 1'b0;
      end
      pend_m = 3'b000;
      out_m  = 3'b000;
    end else begin
      rise = 3'b000;
      for (int c = 0; c < 3; c++) begin
        all_same = 1'b1;
        for (int i = 1; i <= DC; i++) if (samp[c][i] != samp[c][1]) all_same = 1'b0;
        if (all_same && samp[c][1] != deb_m[c]) begin
          deb_m[c] = samp[c][1];
          if (deb_m[c]) rise[c] = 1'b1;
        end
      end
      if (pend_m[0])      out_m = 3'b001;
      else if (pend_m[1]) out_m = 3'b010;
      else if (pend_m[2]) out_m = 3'b100;
      else                out_m = 3'b000;
      pend_m = (pend_m & ~out_m) | rise;
      for (int c = 0; c < 3; c++) begin
        for (int i = DC; i >= 1; i--) samp[c][i] = samp[c][i-1];
        samp[c][0] = press[c];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int coin_edge = -1;
    rst = 1'b1;
    press = 3'b111;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({o_sprite, o_coffee, o_coin, o_busy} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got out=%b busy=%b want out=000 busy=0",
                 n, {o_sprite, o_coffee, o_coin}, o_busy);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (o_coin && coin_edge < 0) coin_edge = n;
      checks++;
      if ({o_sprite, o_coffee, o_coin} !== out_m || o_busy !== (|pend_m)) begin
        failures++;
        $display("FAIL reset_model edge=%0d got out=%b busy=%b want out=%b busy=%b",
                 n, {o_sprite, o_coffee, o_coin}, o_busy, out_m, |pend_m);
      end
    end
    checks++;
    if (coin_edge !== 7) begin
      failures++;
      $display("FAIL reset_redetect got coin edge=%0d want 7", coin_edge);
    end
    press = 3'b000;
    for (int n = 0; n < DC + 6; n++) tick();
  endtask

  task automatic test_clean_press();
    int first = -1;
    int pulses = 0;
    press = 3'b001;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (o_coin) begin
        pulses++;
        if (first < 0) first = n;
      end
      checks++;
      if ({o_sprite, o_coffee, o_coin} !== out_m || o_busy !== (|pend_m)) begin
        failures++;
        $display("FAIL clean_model edge=%0d got out=%b busy=%b want out=%b busy=%b",
                 n, {o_sprite, o_coffee, o_coin}, o_busy, out_m, |pend_m);
      end
    end
    checks++;
    if (first !== 6 || pulses !== 1) begin
      failures++;
      $display("FAIL clean_timing got edge=%0d pulses=%0d want edge=6 pulses=1", first, pulses);
    end
    press = 3'b000;
    for (int n = 0; n < DC + 6; n++) tick();
  endtask

  task automatic test_bounce();
    int pairs = $urandom_range(2, 4);
    int first = -1;
    int pulses = 0;
    for (int n = 0; n < 2 * pairs + 16; n++) begin
      press = (n < 2 * pairs && n[0]) ? 3'b000 : 3'b010;
      tick();
      if (o_coffee) begin
        pulses++;
        if (first < 0) first = n;
      end
      checks++;
      if ({o_sprite, o_coffee, o_coin} !== out_m || o_busy !== (|pend_m)) begin
        failures++;
        $display("FAIL bounce_model edge=%0d got out=%b busy=%b want out=%b busy=%b",
                 n, {o_sprite, o_coffee, o_coin}, o_busy, out_m, |pend_m);
      end
    end
    checks++;
    if (first !== 2 * pairs + 6 || pulses !== 1) begin
      failures++;
      $display("FAIL bounce_timing got edge=%0d pulses=%0d want edge=%0d pulses=1",
               first, pulses, 2 * pairs + 6);
    end
    press = 3'b000;
    for (int n = 0; n < DC + 6; n++) tick();
  endtask

  task automatic test_glitch();
    int len = $urandom_range(1, DC - 1);
    int seen = 0;
    for (int n = 0; n < len + 12; n++) begin
      press = (n < len) ? 3'b100 : 3'b000;
      tick();
      if (o_sprite || o_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL glitch got %0d active cycles (len=%0d) want 0", seen, len);
    end
  endtask

  task automatic test_simultaneous();
    int e_coin = -1, e_coffee = -1, e_sprite = -1;
    int busy_cycles = 0;
    press = 3'b111;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (o_coin && e_coin < 0) e_coin = n;
      if (o_coffee && e_coffee < 0) e_coffee = n;
      if (o_sprite && e_sprite < 0) e_sprite = n;
      if (o_busy) busy_cycles++;
      checks++;
      if ({o_sprite, o_coffee, o_coin} !== out_m || o_busy !== (|pend_m)) begin
        failures++;
        $display("FAIL simul_model edge=%0d got out=%b busy=%b want out=%b busy=%b",
                 n, {o_sprite, o_coffee, o_coin}, o_busy, out_m, |pend_m);
      end
    end
    checks++;
    if (e_coin !== 6 || e_coffee !== 7 || e_sprite !== 8 || busy_cycles !== 3) begin
      failures++;
      $display("FAIL simul_order got coin=%0d coffee=%0d sprite=%0d busy=%0d want 6 7 8 busy=3",
               e_coin, e_coffee, e_sprite, busy_cycles);
    end
    press = 3'b000;
    for (int n = 0; n < DC + 6; n++) tick();
  endtask

  task automatic test_random();
    int cyc = 0;
    int pulses = 0;
    while (cyc < 2000) begin
      int seg = $urandom_range(1, 9);
      press = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 39) == 0);
      if (rst) seg = $urandom_range(1, 3);
      for (int n = 0; n < seg; n++) begin
        tick();
        cyc++;
        if (o_coin || o_coffee || o_sprite) pulses++;
        checks++;
        if ({o_sprite, o_coffee, o_coin} !== out_m || o_busy !== (|pend_m)) begin
          failures++;
          $display("FAIL random_model cyc=%0d rst=%b press=%b got out=%b busy=%b want out=%b busy=%b",
                   cyc, rst, press, {o_sprite, o_coffee, o_coin}, o_busy, out_m, |pend_m);
        end
        checks++;
        if (!$onehot0({o_sprite, o_coffee, o_coin})) begin
          failures++;
          $display("FAIL random_onehot cyc=%0d got out=%b want one-hot or zero",
                   cyc, {o_sprite, o_coffee, o_coin});
        end
      end
    end
    rst = 1'b0;
    checks++;
    if (pulses == 0) begin
      failures++;
      $display("FAIL random_activity got 0 pulses want >0");
    end
  endtask

  initial begin
    rst = 1'b1;
    press = 3'b000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
